// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the iterative divider.
//   state_t        : divider FSM states
//   DIV_WIDTH_DEF  : default operand/result width
//   DIV_LATENCY    : clocks from the edge that samples div to the done pulse
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } state_t;

  localparam int DIV_WIDTH_DEF = 32;

  function automatic int div_latency(input int width);
    return width + 2;
  endfunction

  localparam int DIV_LATENCY = div_latency(DIV_WIDTH_DEF);

endpackage

// File: rtl/div_step.sv
// div_step -- one restoring shift-subtract iteration (combinational).
//   rem_in   : current partial remainder (always < divisor)
//   shift_in : next dividend bit shifted into the remainder
//   divisor  : divisor magnitude
//   rem_out  : partial remainder after this iteration
//   q_bit    : quotient bit produced by this iteration
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_in, shift_in};
  assign diff    = shifted - {1'b0, divisor};

  // No borrow out of the top bit means the divisor fits; since rem_in < divisor
  // the restored or subtracted value always fits back into WIDTH bits.
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// div_unit -- multi-cycle restoring divider with registered results.
// Build option: define DIV_SIGNED_EN for two's-complement division
// (quotient truncated toward zero, remainder follows the dividend's sign);
// otherwise operands are unsigned and the FIX state passes results through.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   dloadab         : latch a/b into the operand registers (ignored while busy)
//   div             : start pulse (ignored unless idle)
//   a, b            : dividend, divisor
//   hi, lo          : remainder, quotient (registered)
//   divZero         : divisor-zero flag, held until the next accepted load
//   busy            : division in progress
//   done            : one-cycle pulse when hi/lo or divZero become valid
//
// state | meaning
// IDLE  | waiting for div; operand loads accepted
// CALC  | first cycle (busy=0) forms magnitudes, then WIDTH shift-subtract steps
// FIX   | sign correction, write hi/lo, pulse done
// ZERO  | divisor was zero: raise divZero, pulse done
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dloadab,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divZero,
  output logic             busy,
  output logic             done
);

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t state, state_nxt;

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             neg_q, neg_r;
  logic [CW-1:0]    cnt;

  logic             load_ok, start, b_eff_zero;
  logic [WIDTH-1:0] b_eff;
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] res_q, res_r;
  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;

  assign load_ok = dloadab && (state == IDLE) && !busy;
  assign start   = div && (state == IDLE) && !busy;

  // A load in the same cycle as div wins, so the zero test looks at the incoming b.
  assign b_eff      = load_ok ? b : op_b;
  assign b_eff_zero = (b_eff == '0);

  assign sgn_a = SIGNED_EN & op_a[WIDTH-1];
  assign sgn_b = SIGNED_EN & op_b[WIDTH-1];
  assign mag_a = sgn_a ? (~op_a + WIDTH'(1)) : op_a;
  assign mag_b = sgn_b ? (~op_b + WIDTH'(1)) : op_b;

  // Most-negative / -1 yields magnitude 2^(WIDTH-1) with neg_q=0, which reads
  // back as the most-negative value again: the wrap is the intended result.
  assign res_q = neg_q ? (~quo + WIDTH'(1)) : quo;
  assign res_r = neg_r ? (~rem + WIDTH'(1)) : rem;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (rem),
    .shift_in (quo[WIDTH-1]),
    .divisor  (dvs),
    .rem_out  (rem_nxt),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = b_eff_zero ? ZERO : CALC;
      CALC:    if (busy && (cnt == '0)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      ZERO:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a    <= '0;
      op_b    <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      divZero <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      // busy rises after the magnitude cycle and drops with the FIX write.
      busy <= (state == CALC);
      if (load_ok) begin
        op_a    <= a;
        op_b    <= b;
        divZero <= 1'b0;
      end
      case (state)
        CALC: begin
          if (!busy) begin
            rem   <= '0;
            quo   <= mag_a;
            dvs   <= mag_b;
            neg_q <= sgn_a ^ sgn_b;
            neg_r <= sgn_a;
            cnt   <= CW'(WIDTH - 1);
          end else begin
            rem <= rem_nxt;
            quo <= {quo[WIDTH-2:0], q_bit};
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          lo   <= res_q;
          hi   <= res_r;
          done <= 1'b1;
        end
        ZERO: begin
          divZero <= 1'b1;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  import div_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, dloadab, div;
  logic [W-1:0] a, b, hi, lo;
  logic         divZero, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .dloadab (dloadab),
    .div     (div),
    .a       (a),
    .b       (b),
    .hi      (hi),
    .lo      (lo),
    .divZero (divZero),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference division from plain arithmetic on the operand values.
  task automatic model(input logic [W-1:0] va, input logic [W-1:0] vb,
                       output logic [W-1:0] q, output logic [W-1:0] r);
`ifdef DIV_SIGNED_EN
    int sa, sb;
    sa = int'(va);
    sb = int'(vb);
    if (va == 32'h8000_0000 && vb == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
`else
    q = va / vb;
    r = va % vb;
`endif
  endtask

  // Issue div (optionally with a same-cycle load) and wait a bounded time for done.
  // lat counts clocks after the sampling edge; inj_at>0 fires a stray div+load mid-run.
  task automatic run_div(input logic [W-1:0] va, input logic [W-1:0] vb, input bit load,
                         input int inj_at, output int lat, output int busy_cnt,
                         output bit stable);
    logic [W-1:0] lo0, hi0;
    lo0 = lo;
    hi0 = hi;
    @(negedge clk);
    a = va; b = vb; dloadab = load; div = 1'b1;
    @(posedge clk); #1;
    dloadab = 1'b0; div = 1'b0;
    lat = -1; busy_cnt = 0; stable = 1'b1;
    for (int k = 1; k <= DIV_LATENCY + 10; k++) begin
      @(posedge clk); #1;
      dloadab = 1'b0; div = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
      if (lo !== lo0 || hi !== hi0) stable = 1'b0;
      if (k == inj_at) begin
        a = 32'd9; b = 32'd1; dloadab = 1'b1; div = 1'b1;
      end
    end
  endtask

  int           lat, bcnt;
  bit           stab;
  logic [W-1:0] eq, er, plo, phi;
  bit           saw_done;

  initial begin
    // Expected values derived by hand from the division rules.
    vecs[0] = '{32'd100,      32'd7,        32'd14,         32'd2};
    vecs[1] = '{32'd1000,     32'd10,       32'd100,        32'd0};
    vecs[2] = '{32'd7,        32'd100,      32'd0,          32'd7};
    vecs[3] = '{32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFF,  32'd0};
`ifdef DIV_SIGNED_EN
    vecs[4] = '{32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    vecs[6] = '{32'd12345,    32'hFFFF_FFFB, 32'hFFFF_F65B, 32'd0};
    vecs[7] = '{32'hFFFF_FFEF, 32'd5,       32'hFFFF_FFFD,  32'hFFFF_FFFE};
`else
    vecs[4] = '{32'hFFFF_FFF9, 32'd2,       32'h7FFF_FFFC,  32'd1};
    vecs[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
    vecs[6] = '{32'd12345,    32'hFFFF_FFFB, 32'd0,         32'd12345};
    vecs[7] = '{32'hFFFF_FFEF, 32'd5,       32'h3333_332F,  32'd4};
`endif

    reset = 1'b1; dloadab = 1'b0; div = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset divZero", divZero, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);

    // 100/7 with latency and busy window
    run_div(32'd100, 32'd7, 1'b1, 0, lat, bcnt, stab);
    check("basic latency", lat, DIV_LATENCY);
    check("basic busy cycles", bcnt, W + 1);
    check("basic lo", lo, 32'd14);
    check("basic hi", hi, 32'd2);
    check("basic divZero", divZero, 0);
    check("basic hi/lo stable", stab, 1);
    @(posedge clk); #1;
    check("basic done one cycle", done, 0);
    check("basic busy after", busy, 0);

    // divide by zero
    run_div(32'd5, 32'd0, 1'b1, 0, lat, bcnt, stab);
    check("zero latency", lat, 1);
    check("zero divZero", divZero, 1);
    check("zero lo kept", lo, 32'd14);
    check("zero hi kept", hi, 32'd2);
    check("zero busy", bcnt, 0);
    @(posedge clk); #1;
    check("zero done one cycle", done, 0);
    repeat (3) @(posedge clk); #1;
    check("zero divZero held", divZero, 1);
    check("zero busy never", busy, 0);
    @(negedge clk); a = 32'd100; b = 32'd7; dloadab = 1'b1;
    @(posedge clk); #1; dloadab = 1'b0;
    check("load clears divZero", divZero, 0);

    // vector table
    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i].a, vecs[i].b, 1'b1, 0, lat, bcnt, stab);
      check($sformatf("vec%0d latency", i), lat, DIV_LATENCY);
      check($sformatf("vec%0d lo", i), lo, vecs[i].lo);
      check($sformatf("vec%0d hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d divZero", i), divZero, 0);
    end

    // stray div and load (b=1) during CALC are ignored
    run_div(32'd100, 32'd7, 1'b1, 5, lat, bcnt, stab);
    check("midcalc latency", lat, DIV_LATENCY);
    check("midcalc lo", lo, 32'd14);
    check("midcalc hi", hi, 32'd2);
    run_div(32'd0, 32'd0, 1'b0, 0, lat, bcnt, stab);
    check("midcalc rerun latency", lat, DIV_LATENCY);
    check("midcalc operands kept lo", lo, 32'd14);
    check("midcalc operands kept hi", hi, 32'd2);

    // reset 10 cycles into a division
    @(negedge clk); a = 32'd1000; b = 32'd3; dloadab = 1'b1; div = 1'b1;
    @(posedge clk); #1; dloadab = 1'b0; div = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("abort busy", busy, 0);
    check("abort state", W'(dut.state), W'(IDLE));
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    check("abort done", done, 0);
    @(negedge clk); reset = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < DIV_LATENCY + 5; k++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("abort no done", saw_done, 0);
    check("abort lo stays", lo, 0);

    // randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = W'($urandom_range(1, 15));
        1:       rb = $urandom;
        2:       rb = '0;
        default: rb = 32'hFFFF_FFFF - W'($urandom_range(0, 15));
      endcase
      if (i % 5 == 0) ra = 32'h8000_0000;
      plo = lo; phi = hi;
      run_div(ra, rb, 1'b1, 0, lat, bcnt, stab);
      if (rb == '0) begin
        check($sformatf("rand%0d zero latency", i), lat, 1);
        check($sformatf("rand%0d zero flag", i), divZero, 1);
        check($sformatf("rand%0d zero lo", i), lo, plo);
        check($sformatf("rand%0d zero hi", i), hi, phi);
      end else begin
        model(ra, rb, eq, er);
        check($sformatf("rand%0d latency", i), lat, DIV_LATENCY);
        check($sformatf("rand%0d lo a=%h b=%h", i, ra, rb), lo, eq);
        check($sformatf("rand%0d hi a=%h b=%h", i, ra, rb), hi, er);
        check($sformatf("rand%0d flag", i), divZero, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port dloadab  input  1  latch a/b into the operand registers.
REQ-005 SHALL have port div  input  1  start-division pulse from the control unit.
REQ-006 SHALL have port a  input  WIDTH  dividend (register A).
REQ-007 SHALL have port b  input  WIDTH  divisor (register B).
REQ-008 SHALL have port hi  output  WIDTH  remainder, registered.
REQ-009 SHALL have port lo  output  WIDTH  quotient, registered.
REQ-010 SHALL have port divZero  output  1  divisor-zero exception flag, registered.
REQ-011 SHALL have port busy  output  1  high while a division is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when hi/lo or divZero become valid.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX, ZERO.
REQ-014 SHALL, when dloadab=1 and busy=0, capture a and b into the operand registers at the clock edge.
REQ-015 SHALL ignore dloadab while busy=1.
REQ-016 SHALL, when div=1 in IDLE with a nonzero latched divisor, go to CALC and set busy=1 on the next cycle.
REQ-017 SHALL, when dloadab=1 and div=1 in the same cycle, use the a/b values present in that cycle (load before start).
REQ-018 SHALL, when div=1 in IDLE with a zero divisor, go to ZERO, set divZero=1, pulse done for one cycle, leave hi/lo unchanged, then return to IDLE.
REQ-019 SHALL hold divZero=1 until the next accepted dloadab or reset.
REQ-020 SHALL execute one restoring shift-subtract step per cycle in CALC, for exactly WIDTH cycles, on operand magnitudes.
REQ-021 SHALL, in FIX, apply sign correction, write lo=quotient and hi=remainder, pulse done, and return to IDLE.
REQ-022 SHALL assert done exactly WIDTH+2 clocks after the edge that sampled div (34 for WIDTH=32); busy SHALL be high for the WIDTH+1 cycles before done.
REQ-023 SHALL ignore div while busy=1.
REQ-024 SHALL keep hi/lo stable except at the FIX write.

Reset
REQ-025 SHALL, while reset=1, force state=IDLE and clear hi, lo, the operand registers, divZero, busy and done to 0.
REQ-026 SHALL abort any in-progress division on reset without writing hi/lo; this has priority over dloadab and div.

Configuration
REQ-027 SHALL, with DIV_SIGNED_EN defined, divide two's-complement operands: quotient truncated toward zero, remainder takes the dividend's sign.
REQ-028 SHALL, with DIV_SIGNED_EN defined, return lo=0x80000000 and hi=0 for 0x80000000/0xFFFFFFFF, with no flag raised.
REQ-029 SHALL, without DIV_SIGNED_EN, divide unsigned operands, make FIX a pass-through, and keep the same latency.

Structure
REQ-030 SHALL place the FSM state typedef, the WIDTH default and the latency constant (WIDTH+2) in shared package div_pkg.
REQ-031 SHALL implement one restoring iteration in a combinational sub-module div_step (partial remainder, divisor -> next remainder, quotient bit), instantiated once.

Verification
REQ-032 SHALL verify: load a=100, b=7; div -> done at cycle 34, lo=14, hi=2, divZero=0.
REQ-033 SHALL verify (signed): a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-034 SHALL verify: a=5, b=0; div -> divZero=1 and done pulse 1 cycle after start, hi/lo unchanged, busy never high.
REQ-035 SHALL verify: a=0x80000000, b=0xFFFFFFFF (signed) -> lo=0x80000000, hi=0.
REQ-036 SHALL verify: reset asserted 10 cycles after div -> next cycle busy=0, state IDLE, hi=lo=0, no done pulse.
REQ-037 SHALL verify: a second div and a dloadab with b=1 issued mid-CALC -> both ignored, first result (100/7) delivered at cycle 34.
